encoder_sys: RTL
================

ENCODER_SYS -- requirements
Module: encoder_sys

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 16, payload bits per frame (legal 4..64).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1, rising-edge clock for all state.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port data_in, input, DATA_W, payload word, transmitted MSB first.
REQ-006 Port in_valid, input, 1, data_in valid.
REQ-007 Port in_ready, output, 1, block can accept a word.
REQ-008 Port encoded_bits, output, 2, code symbol; [1] = G0 (111), [0] = G1 (101).
REQ-009 Port out_valid, output, 1, encoded_bits valid.
REQ-010 Port out_ready, input, 1, downstream accepts symbol.
REQ-011 Port frame_last, output, 1, current symbol is the last of the frame.
REQ-012 Port busy, output, 1, frame in progress (state not IDLE).

Function
REQ-013 The block SHALL implement the rate-1/2, K=3 convolutional code: with u = current bit, s1 = previous bit, s2 = bit before s1, encoded_bits[1] = u^s1^s2 and encoded_bits[0] = u^s2.
REQ-014 The trellis SHALL be: state (s2,s1) 00: u0->00, u1->11; 01: u0->10, u1->01; 10: u0->11, u1->00; 11: u0->01, u1->10.
REQ-015 FSM states SHALL be IDLE, DATA, TAIL; reset state IDLE.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, load data_in into the shift register, clear bit counter, go to DATA.
REQ-017 The first symbol SHALL be valid the cycle after acceptance (1-cycle latency); in_ready SHALL be 0 in DATA and TAIL.
REQ-018 DATA/TAIL: out_valid=1; encoded_bits SHALL be derived only from registered state and stay stable while out_ready=0.
REQ-019 A symbol SHALL be consumed only on out_valid&&out_ready; on consume, s2<=s1, s1<=u, the shift register shifts left, and the counter increments.
REQ-020 Consuming data symbol DATA_W-1 SHALL move to TAIL (TAIL_EN) or IDLE (no TAIL_EN).
REQ-021 TAIL SHALL emit exactly 2 symbols with u=0; consuming the second SHALL return to IDLE with s1=s2=0.
REQ-022 frame_last SHALL be 1 only while the final symbol of the frame is presented (out_valid=1).
REQ-023 encoded_bits SHALL be 2'b00 whenever out_valid=0.
REQ-024 in_valid while busy SHALL be ignored; data_in is not re-sampled mid-frame.
REQ-025 The counter SHALL be $clog2(DATA_W+2) bits wide and never wrap within a frame.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, out_valid=0, encoded_bits=00, frame_last=0, busy=0, s1=s2=0, counter=0, shift register=0.
REQ-027 in_ready SHALL be 0 while rst_n is low and 1 from the first clk edge after release.
REQ-028 Reset mid-frame SHALL abandon the frame; no further symbols of it are emitted.

Configuration
REQ-029 Macro ENCODER_TAIL_EN SHALL control zero-tail termination.
REQ-030 With ENCODER_TAIL_EN defined: frame = DATA_W+2 symbols; each frame starts at state 00.
REQ-031 Without it: frame = DATA_W symbols; no TAIL state; s1/s2 carry across frames (continuous stream), cleared only by reset.

Verification
REQ-032 TAIL_EN, data_in=16'h8000, out_ready=1 -> symbols 11,10,11, then 13x 00, then tail 00,00; frame_last on symbol 18.
REQ-033 TAIL_EN, data_in=16'hFFFF -> 11,01, then 14x 10, then tail 01,11; state 00 afterwards.
REQ-034 Backpressure: out_ready=0 for 3 cycles at symbol 5 of 16'hFFFF -> encoded_bits held at 10, counter frozen, no symbol lost or duplicated.
REQ-035 rst_n pulsed low at symbol 6 -> out_valid=0 same cycle, busy=0; next frame 16'h8000 starts with 11.
REQ-036 No TAIL_EN, 16'hFFFF then 16'h0000 -> first frame 16 symbols ending 10 with frame_last; second frame starts 01,11, then 14x 00.
REQ-037 in_valid held high during a frame -> exactly one word accepted per frame; in_ready=1 only in IDLE.

Source files
------------

// File: rtl/encoder_sys.sv
// Rate-1/2 K=3 convolutional encoder (G0=111, G1=101), one payload word per frame; `ENCODER_TAIL_EN adds a 2-symbol zero tail.
// First symbol valid 1 cycle after acceptance; symbols hold while out_ready=0; in_ready only in IDLE.
module encoder_sys #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [1:0]        encoded_bits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_last,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 2);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_W - 1);
`ifdef ENCODER_TAIL_EN
  localparam logic [CW-1:0] LAST_TAIL = CW'(DATA_W + 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              init_q, init_d;

  logic cur_u;
  logic sym_vld;
  logic accept;
  logic consume;
  logic last_data;

  // Tail symbols encode u=0; the shift register is only meaningful in DATA.
  assign cur_u     = (state_q == DATA) ? sr_q[DATA_W-1] : 1'b0;
  assign sym_vld   = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign consume   = sym_vld && out_ready;
  assign last_data = (cnt_q == LAST_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      init_q  <= init_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = DATA;
      end
      DATA: begin
        if (consume && last_data) begin
`ifdef ENCODER_TAIL_EN
          state_d = TAIL;
`else
          state_d = IDLE;
`endif
        end
      end
      TAIL: begin
`ifdef ENCODER_TAIL_EN
        if (consume && (cnt_q == LAST_TAIL)) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Encoder memory (s1/s2) is untouched on load so it carries across frames
  // in continuous mode; with the tail enabled it is already zero here.
  always_comb begin
    init_d = 1'b1;
    sr_d   = sr_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    cnt_d  = cnt_q;
    if (accept) begin
      sr_d  = data_in;
      cnt_d = '0;
    end else if (consume) begin
      s2_d  = s1_q;
      s1_d  = cur_u;
      sr_d  = {sr_q[DATA_W-2:0], 1'b0};
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    in_ready     = init_q && (state_q == IDLE);
    out_valid    = sym_vld;
    busy         = sym_vld;
    encoded_bits = sym_vld ? {cur_u ^ s1_q ^ s2_q, cur_u ^ s2_q} : 2'b00;
`ifdef ENCODER_TAIL_EN
    frame_last   = (state_q == TAIL) && (cnt_q == LAST_TAIL);
`else
    frame_last   = (state_q == DATA) && last_data;
`endif
  end

endmodule
